// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. A request is granted in
// IDLE, its operands are presented to the ALU for one EXEC cycle, and the
// captured result is held in RESP until the consumer takes it.
//
// Handshake semantics (request side and response side alike): a transfer
// happens on a rising clk_i edge where valid and ready are both high. A source
// holding valid keeps its payload stable until that edge. Ready may depend
// combinationally on valid (ReqNReady_o does). Valid never depends on ready.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   Req{0,1}Valid_i/Ready_o    request handshake per requester
//   Req{0,1}SrcA_i/SrcB_i      operands per requester (DATA_WIDTH)
//   Req{0,1}Ctrl_i             3-bit ALU control per requester
//   AluSrcA_o/AluSrcB_o        operands to the shared ALU (registered)
//   AluControl_o               control code to the shared ALU (registered)
//   AluResult_i/AluZero_i      combinational ALU outputs
//   RspValid_o/RspReady_i      response handshake
//   RspResult_o/RspZero_o      captured ALU outputs
//   RspId_o                    id of the requester that was served
//   dbg_state                  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Req0Valid_i,
  input  logic                  Req1Valid_i,
  output logic                  Req0Ready_o,
  output logic                  Req1Ready_o,
  input  logic [DATA_WIDTH-1:0] Req0SrcA_i,
  input  logic [DATA_WIDTH-1:0] Req0SrcB_i,
  input  logic [DATA_WIDTH-1:0] Req1SrcA_i,
  input  logic [DATA_WIDTH-1:0] Req1SrcB_i,
  input  logic [2:0]            Req0Ctrl_i,
  input  logic [2:0]            Req1Ctrl_i,
  output logic [DATA_WIDTH-1:0] AluSrcA_o,
  output logic [DATA_WIDTH-1:0] AluSrcB_o,
  output logic [2:0]            AluControl_o,
  input  logic [DATA_WIDTH-1:0] AluResult_i,
  input  logic                  AluZero_i,
  output logic                  RspValid_o,
  input  logic                  RspReady_i,
  output logic [DATA_WIDTH-1:0] RspResult_o,
  output logic                  RspZero_o,
  output logic                  RspId_o,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_ptr_q;   // preferred requester when both are valid
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic [2:0]            op_ctrl_q;
  logic                  op_id_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_zero_q;
  logic                  rsp_id_q;

  logic grant0, grant1;
  logic rsp_done;

  // Grant logic: a lone valid requester always wins; on contention the
  // round-robin pointer decides. Only meaningful in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = Req0Valid_i && (!Req1Valid_i || !rr_ptr_q);
      grant1 = Req1Valid_i && (!Req0Valid_i ||  rr_ptr_q);
    end
  end

  assign rsp_done = (state_q == RESP) && RspReady_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 || grant1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (RspReady_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= 3'b000;
      op_id_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0) begin
        op_a_q    <= Req0SrcA_i;
        op_b_q    <= Req0SrcB_i;
        op_ctrl_q <= Req0Ctrl_i;
        op_id_q   <= 1'b0;
      end else if (grant1) begin
        op_a_q    <= Req1SrcA_i;
        op_b_q    <= Req1SrcB_i;
        op_ctrl_q <= Req1Ctrl_i;
        op_id_q   <= 1'b1;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= AluResult_i;
        rsp_zero_q   <= AluZero_i;
        rsp_id_q     <= op_id_q;
      end
      // Pointer moves only once the response has actually been consumed, so
      // an operation lost to reset does not affect fairness.
      if (rsp_done) rr_ptr_q <= ~rsp_id_q;
    end
  end

  assign Req0Ready_o  = grant0;
  assign Req1Ready_o  = grant1;
  assign AluSrcA_o    = op_a_q;
  assign AluSrcB_o    = op_b_q;
  assign AluControl_o = op_ctrl_q;
  assign RspValid_o   = (state_q == RESP);
  assign RspResult_o  = rsp_result_q;
  assign RspZero_o    = rsp_zero_q;
  assign RspId_o      = rsp_id_q;
  assign dbg_state    = state_q;

endmodule
